// File: rtl/display_scan_pkg.sv
// Shared display definitions: hex glyph table, anode decode table, blank code
// and the frame type used by the digit scanner.
package display_scan_pkg;

  typedef enum logic [1:0] {
    DIGIT0 = 2'd0,
    DIGIT1 = 2'd1,
    DIGIT2 = 2'd2,
    DIGIT3 = 2'd3
  } digit_e;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
  } frame_t;

  localparam logic [7:0] BLANK = 8'hFF;

  // Active-low g..a glyphs, entry [n] is hex digit n (0-9, A, b, C, d, E, F).
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [3:0][3:0] ANODE_ONEHOT = {
    4'b0111, 4'b1011, 4'b1101, 4'b1110
  };

  // True when every nibble from position k up to the top of v is zero.
  function automatic logic upper_zero(input logic [15:0] v, input logic [1:0] k);
    return (v >> {k, 2'b00}) == 16'h0000;
  endfunction

endpackage

// File: rtl/display_scan_display7seg.sv
// Hex nibble to active-low seven-segment glyph (g..a); decimal point is
// handled by the caller.
module display7seg
  import display_scan_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = HEX_GLYPH[hex_i];
  end

endmodule

// File: rtl/display_scan.sv
// Four-digit multiplexed seven-segment scanner with frame-synchronous value
// update and optional leading-zero blanking.
module display_scan
  import display_scan_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        pending
);

  logic [15:0] cnt_q, cnt_d;
  digit_e      idx_q, idx_d;
  frame_t      disp_q, disp_d;
  frame_t      pend_q, pend_d;
  logic        pending_q, pending_d;
  logic [3:0]  an_q, an_d;
  logic [7:0]  seg_q, seg_d;

  logic        tick;
  logic        boundary;
  logic        blank;
  logic [3:0]  nib;
  logic [6:0]  glyph;

  always_comb begin
    tick     = (cnt_q == 16'(CLK_DIV - 1));
    boundary = tick && (idx_q == DIGIT3);
    cnt_d    = tick ? '0 : cnt_q + 16'd1;
    idx_d    = tick ? digit_e'(idx_q + 2'd1) : idx_q;
  end

  // A load on the boundary cycle bypasses the pending buffer so the new
  // frame starts with it and nothing is left pending.
  always_comb begin
    pend_d    = pend_q;
    pending_d = pending_q;
    disp_d    = disp_q;
    if (load) begin
      pend_d    = '{val: value, dp: dp_mask};
      pending_d = 1'b1;
    end
    if (boundary) begin
      if (load) begin
        disp_d = '{val: value, dp: dp_mask};
      end else if (pending_q) begin
        disp_d = pend_q;
      end
      pending_d = 1'b0;
    end
  end

  // Outputs are computed from the post-edge index and frame so the slot
  // shown after a tick is consistent with a freshly transferred value.
  always_comb begin
    nib   = disp_d.val[{idx_d, 2'b00} +: 4];
    blank = blank_lz && (idx_d != DIGIT0) && upper_zero(disp_d.val, idx_d);
    an_d  = an_q;
    seg_d = seg_q;
    if (tick) begin
      if (blank) begin
        an_d  = '1;
        seg_d = BLANK;
      end else begin
        an_d  = ANODE_ONEHOT[idx_d];
        seg_d = {~disp_d.dp[idx_d], glyph};
      end
    end
  end

  display7seg u_dec (
    .hex_i (nib),
    .seg_o (glyph)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= DIGIT0;
      disp_q    <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
      an_q      <= 4'b1110;
      seg_q     <= 8'hC0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an      = an_q;
  assign seg     = seg_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_display_scan;

  localparam int unsigned D     = 4;
  localparam int unsigned FRAME = 4 * D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        pending;

  display_scan #(.CLK_DIV(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .value    (value),
    .dp_mask  (dp_mask),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          run_cmp = 1'b0;

  // Behavioural model: e counts clock edges since reset release; a digit
  // slot lasts D edges and a frame lasts 4*D edges.
  logic [7:0]  GLY [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int unsigned e;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_disp_dp, m_pend_dp;
  bit          m_pflag;
  logic [3:0]  exp_an;
  logic [7:0]  exp_seg;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e = 0;
    m_disp = '0; m_pend = '0; m_disp_dp = '0; m_pend_dp = '0;
    m_pflag = 1'b0;
    exp_an = 4'b1110;
    exp_seg = 8'hC0;
  endtask

  task automatic model_edge();
    int unsigned slot;
    logic [15:0] upper;
    if (rst) begin
      model_reset();
      return;
    end
    e++;
    if (load) begin
      m_pend = value; m_pend_dp = dp_mask; m_pflag = 1'b1;
    end
    if (e % FRAME == 0) begin
      if (m_pflag) begin
        m_disp = m_pend; m_disp_dp = m_pend_dp;
      end
      m_pflag = 1'b0;
    end
    if (e % D == 0) begin
      slot  = (e / D) % 4;
      upper = m_disp >> (4 * slot);
      if (blank_lz && slot != 0 && upper == 16'h0000) begin
        exp_an  = 4'hF;
        exp_seg = 8'hFF;
      end else begin
        exp_an  = ~(4'(1) << slot);
        exp_seg = {~m_disp_dp[slot], GLY[upper[3:0]][6:0]};
      end
    end
  endtask

  // Inputs change 1 time unit after the edge, once the model has consumed them.
  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic wait_phase(input int unsigned ph);
    for (int i = 0; i < 64; i++) begin
      if (e % FRAME == ph) return;
      step();
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_phase: got phase %0d expected %0d", e % FRAME, ph);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    load = 1'b1; value = v; dp_mask = dp;
    step();
    load = 1'b0;
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      check("an_stream", {4'h0, an}, {4'h0, exp_an});
      check("seg_stream", seg, exp_seg);
      check("pending_stream", {7'h0, pending}, {7'h0, m_pflag});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] an_seq [4];
    an_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    model_reset();
    run_cmp = 1'b1;
    repeat (3) step();
    #2;
    check("reset_an", {4'h0, an}, 8'h0E);
    check("reset_seg", seg, 8'hC0);
    check("reset_pending", {7'h0, pending}, 8'h00);
    rst = 1'b0;

    // First tick exactly D edges after release; idle frame shows "0" everywhere.
    repeat (3) step();
    check("pre_tick_an", {4'h0, an}, 8'h0E);
    for (int k = 1; k <= 4; k++) begin
      repeat (4) step();
      check("idle_an", {4'h0, an}, {4'h0, an_seq[k % 4]});
      check("idle_seg", seg, 8'hC0);
    end

    // Mid-frame load: old value held until the boundary, dp bit 2 marks digit 2.
    wait_phase(5);
    do_load(16'h12AF, 4'b0100);
    check("load_pending", {7'h0, pending}, 8'h01);
    wait_phase(8);
    check("old_kept_seg", seg, 8'hC0);
    wait_phase(15);
    check("pending_held", {7'h0, pending}, 8'h01);
    step();
    check("boundary_pending", {7'h0, pending}, 8'h00);
    check("d0_seg_F", seg, 8'h8E);
    repeat (4) step();
    check("d1_seg_A", seg, 8'h88);
    repeat (4) step();
    check("d2_seg_2dp", seg, 8'h24);
    repeat (4) step();
    check("d3_seg_1", seg, 8'hF9);

    // Leading-zero blanking of 0030.
    blank_lz = 1'b1;
    wait_phase(3);
    do_load(16'h0030, 4'b0000);
    wait_phase(0);
    check("lz_d0_an", {4'h0, an}, 8'h0E);
    check("lz_d0_seg", seg, 8'hC0);
    repeat (4) step();
    check("lz_d1_seg", seg, 8'hB0);
    repeat (4) step();
    check("lz_d2_an", {4'h0, an}, 8'h0F);
    check("lz_d2_seg", seg, 8'hFF);
    repeat (4) step();
    check("lz_d3_seg", seg, 8'hFF);
    blank_lz = 1'b0;

    // Last writer wins; then a load exactly on the boundary cycle.
    wait_phase(2);
    do_load(16'h1111, 4'b0000);
    wait_phase(7);
    do_load(16'h2222, 4'b0000);
    wait_phase(0);
    check("lww_d0_seg", seg, 8'hA4);
    repeat (4) step();
    check("lww_d1_seg", seg, 8'hA4);
    wait_phase(15);
    do_load(16'h3456, 4'b0000);
    check("bnd_pending", {7'h0, pending}, 8'h00);
    check("bnd_an", {4'h0, an}, 8'h0E);
    check("bnd_seg", seg, 8'h82);

    // Reset mid-frame with a value pending; a load during reset is ignored.
    wait_phase(3);
    do_load(16'hABCD, 4'b1111);
    wait_phase(6);
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_mid_an", {4'h0, an}, 8'h0E);
    check("rst_mid_seg", seg, 8'hC0);
    check("rst_mid_pending", {7'h0, pending}, 8'h00);
    load = 1'b1; value = 16'hFFFF; dp_mask = 4'hF;
    step();
    step();
    load = 1'b0;
    rst = 1'b0;
    repeat (3) step();
    check("rel_pre_an", {4'h0, an}, 8'h0E);
    step();
    check("rel_tick_an", {4'h0, an}, 8'h0D);
    check("rel_tick_seg", seg, 8'hC0);
    check("rel_pending", {7'h0, pending}, 8'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      load    = ($urandom_range(0, 7) == 0);
      value   = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp_mask = 4'($urandom);
      if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
      if (rst) begin
        if ($urandom_range(0, 2) == 0) rst = 1'b0;
      end else if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        model_reset();
      end
      step();
    end
    rst = 1'b0;
    load = 1'b0;
    repeat (2) step();

    @(posedge clk);
    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
